vscpu_mem_arbiter: RTL and testbench

VSCPU_MEM_ARBITER -- requirements
Module: vscpu_mem_arbiter

---
 rtl/vscpu_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_vscpu_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vscpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NUM_CORES
// VerySimpleCPU cores, with per-access timeout and sticky per-core error flags.
//
// state | meaning
// IDLE  | waiting for an eligible core_req; grants from rr_ptr upward
// ISSUE | mem_ctrl_req held high until mem_ctrl_vld or timeout
// RESP  | one-cycle core_vld pulse to the granted core
module vscpu_mem_arbiter #(
    parameter int NUM_CORES  = 3,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    localparam int IDX_W      = $clog2(NUM_CORES),
    localparam int MEM_ADDR_W = ADDR_W + IDX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    input  logic [NUM_CORES-1:0]        core_done,
    output logic [NUM_CORES-1:0]        core_vld,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_ctrl_req,
    output logic                        mem_ctrl_we,
    output logic [MEM_ADDR_W-1:0]       mem_ctrl_addr,
    output logic [DATA_W-1:0]           mem_ctrl_in,
    input  logic [DATA_W-1:0]           mem_ctrl_out,
    input  logic                        mem_ctrl_vld,
    output logic [NUM_CORES-1:0]        err,
    output logic                        all_done
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 excl_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 mem_req_q;
    logic [NUM_CORES-1:0] core_vld_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [NUM_CORES-1:0] err_q;
    logic                 all_done_q;

    logic [NUM_CORES-1:0] elig;
    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 timeout_hit;

    // The core just served sits out the first IDLE cycle so others get a turn.
    always_comb begin
        elig      = core_req;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (excl_q) begin
            elig[gnt_idx_q] = 1'b0;
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_CORES);
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign rr_ptr_d    = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + IDX_W'(1);
    assign cnt_d       = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            cnt_q      <= '0;
            excl_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_req_q  <= 1'b0;
            core_vld_q <= '0;
            rdata_q    <= '0;
            err_q      <= '0;
            all_done_q <= 1'b0;
        end else begin
            core_vld_q <= '0;
            excl_q     <= 1'b0;
            all_done_q <= &core_done;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        state_q   <= ISSUE;
                        gnt_idx_q <= grant_idx;
                        rr_ptr_q  <= rr_ptr_d;
                        we_q      <= core_we[grant_idx];
                        addr_q    <= core_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        wdata_q   <= core_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                        mem_req_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                ISSUE: begin
                    // A response arriving on the timeout cycle still wins.
                    if (mem_ctrl_vld) begin
                        state_q               <= RESP;
                        rdata_q               <= mem_ctrl_out;
                        mem_req_q             <= 1'b0;
                        core_vld_q[gnt_idx_q] <= 1'b1;
                        cnt_q                 <= '0;
                    end else if (timeout_hit) begin
                        state_q               <= RESP;
                        rdata_q               <= '1;
                        mem_req_q             <= 1'b0;
                        core_vld_q[gnt_idx_q] <= 1'b1;
                        err_q[gnt_idx_q]      <= 1'b1;
                        cnt_q                 <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    excl_q  <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_vld      = core_vld_q;
    assign core_rdata    = rdata_q;
    assign mem_ctrl_req  = mem_req_q;
    assign mem_ctrl_we   = we_q;
    assign mem_ctrl_addr = {gnt_idx_q, addr_q};
    assign mem_ctrl_in   = wdata_q;
    assign err           = err_q;
    assign all_done      = all_done_q;

endmodule

// File: tb/tb_vscpu_mem_arbiter.sv
// Directed bench for vscpu_mem_arbiter (3 cores, TIMEOUT=4): latency, round-robin
// order, back-to-back exclusion, timeout/error, async reset and all_done.
module tb_vscpu_mem_arbiter;

    localparam int NC  = 3;
    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int TO  = 4;
    localparam int MAW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]    core_req, core_we, core_done, core_vld, err;
    logic [NC*AW-1:0] core_addr;
    logic [NC*DW-1:0] core_wdata;
    logic [DW-1:0]    core_rdata, mem_ctrl_in, mem_ctrl_out;
    logic             mem_ctrl_req, mem_ctrl_we, mem_ctrl_vld, all_done;
    logic [MAW-1:0]   mem_ctrl_addr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vscpu_mem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_done     (core_done),
        .core_vld      (core_vld),
        .core_rdata    (core_rdata),
        .mem_ctrl_req  (mem_ctrl_req),
        .mem_ctrl_we   (mem_ctrl_we),
        .mem_ctrl_addr (mem_ctrl_addr),
        .mem_ctrl_in   (mem_ctrl_in),
        .mem_ctrl_out  (mem_ctrl_out),
        .mem_ctrl_vld  (mem_ctrl_vld),
        .err           (err),
        .all_done      (all_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int w = 0; w < 20 && !mem_ctrl_req; w++) cyc();
        check(tag, 64'(mem_ctrl_req), 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        core_req     = '0;
        core_we      = '0;
        core_done    = '0;
        core_addr    = {14'h00AB, 14'h0005, 14'h0003};
        core_wdata   = {32'h0000_DEAD, 32'h0000_0002, 32'h0000_0001};
        mem_ctrl_out = '0;
        mem_ctrl_vld = 1'b0;
        cyc();
        cyc();
        check("rst_req",   64'(mem_ctrl_req), 64'd0);
        check("rst_vld",   64'(core_vld), 64'd0);
        check("rst_rdata", 64'(core_rdata), 64'd0);
        check("rst_addr",  64'(mem_ctrl_addr), 64'd0);
        check("rst_in",    64'(mem_ctrl_in), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_alldn", 64'(all_done), 64'd0);
        rst_n = 1'b1;
        cyc();

        // core1 read of 0x0005, memory answers two cycles after the request
        core_req = 3'b010;
        check("t1_req_pre", 64'(mem_ctrl_req), 64'd0);
        cyc();
        check("t1_req",  64'(mem_ctrl_req), 64'd1);
        check("t1_addr", 64'(mem_ctrl_addr), 64'h4005);
        check("t1_we",   64'(mem_ctrl_we), 64'd0);
        cyc();
        check("t1_vld_early", 64'(core_vld), 64'd0);
        mem_ctrl_out = 32'h1234_5678;
        mem_ctrl_vld = 1'b1;
        cyc();
        mem_ctrl_vld = 1'b0;
        core_req     = 3'b000;
        check("t1_vld",   64'(core_vld), 64'b010);
        check("t1_rdata", 64'(core_rdata), 64'h1234_5678);
        check("t1_req_lo", 64'(mem_ctrl_req), 64'd0);
        cyc();
        check("t1_vld_1cyc", 64'(core_vld), 64'd0);

        // all three cores request continuously from reset
        rst_n    = 1'b0;
        core_req = 3'b111;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_req("t2_req");
            check("t2_gnt", 64'(mem_ctrl_addr[15:14]), 64'(k % 3));
            mem_ctrl_out = 32'hA000_0000 + 32'(k);
            mem_ctrl_vld = 1'b1;
            cyc();
            mem_ctrl_vld = 1'b0;
            check("t2_vld",   64'(core_vld), 64'd1 << (k % 3));
            check("t2_rdata", 64'(core_rdata), 64'hA000_0000 + 64'(k));
            if (k == 5) core_req = 3'b000;
        end
        cyc();
        cyc();

        // core2 alone, back-to-back: write then another write
        core_req = 3'b100;
        core_we  = 3'b100;
        cyc();
        check("t3_req",  64'(mem_ctrl_req), 64'd1);
        check("t3_addr", 64'(mem_ctrl_addr), 64'h80AB);
        check("t3_we",   64'(mem_ctrl_we), 64'd1);
        check("t3_in",   64'(mem_ctrl_in), 64'h0000_DEAD);
        mem_ctrl_out = 32'h0000_55AA;
        mem_ctrl_vld = 1'b1;
        cyc();
        mem_ctrl_vld = 1'b0;
        check("t3_vld_a",   64'(core_vld), 64'b100);
        check("t3_rdata_a", 64'(core_rdata), 64'h0000_55AA);
        cyc();
        check("t3_idle_a", 64'(mem_ctrl_req), 64'd0);
        cyc();
        check("t3_idle_b", 64'(mem_ctrl_req), 64'd0);
        cyc();
        check("t3_regrant", 64'(mem_ctrl_req), 64'd1);
        mem_ctrl_out = 32'h0000_0077;
        mem_ctrl_vld = 1'b1;
        cyc();
        mem_ctrl_vld = 1'b0;
        core_req     = 3'b000;
        core_we      = 3'b000;
        check("t3_vld_b", 64'(core_vld), 64'b100);
        cyc();
        cyc();

        // TIMEOUT=4, memory silent for core0
        core_req = 3'b001;
        cyc();
        check("t4_req", 64'(mem_ctrl_req), 64'd1);
        cyc();
        cyc();
        cyc();
        check("t4_before_to", 64'(core_vld), 64'd0);
        check("t4_still_req", 64'(mem_ctrl_req), 64'd1);
        cyc();
        core_req = 3'b000;
        check("t4_to_vld",   64'(core_vld), 64'b001);
        check("t4_to_err",   64'(err), 64'b001);
        check("t4_to_rdata", 64'(core_rdata), 64'hFFFF_FFFF);
        check("t4_to_req",   64'(mem_ctrl_req), 64'd0);
        cyc();

        // response on the timeout cycle wins, err unchanged
        core_req = 3'b010;
        cyc();
        check("t4b_addr", 64'(mem_ctrl_addr), 64'h4005);
        cyc();
        cyc();
        cyc();
        mem_ctrl_out = 32'h600D_F00D;
        mem_ctrl_vld = 1'b1;
        cyc();
        mem_ctrl_vld = 1'b0;
        core_req     = 3'b000;
        check("t4b_vld",   64'(core_vld), 64'b010);
        check("t4b_err",   64'(err), 64'b001);
        check("t4b_rdata", 64'(core_rdata), 64'h600D_F00D);
        cyc();

        // core0 served normally after its timeout
        core_req = 3'b001;
        cyc();
        check("t4c_addr", 64'(mem_ctrl_addr), 64'h0003);
        mem_ctrl_out = 32'h0000_1111;
        mem_ctrl_vld = 1'b1;
        cyc();
        mem_ctrl_vld = 1'b0;
        core_req     = 3'b000;
        check("t4c_vld",   64'(core_vld), 64'b001);
        check("t4c_rdata", 64'(core_rdata), 64'h0000_1111);
        check("t4c_err",   64'(err), 64'b001);
        cyc();

        // stray mem_ctrl_vld in IDLE is ignored
        mem_ctrl_vld = 1'b1;
        cyc();
        mem_ctrl_vld = 1'b0;
        check("t5_stray_vld", 64'(core_vld), 64'd0);
        check("t5_stray_req", 64'(mem_ctrl_req), 64'd0);

        // async reset during ISSUE
        core_req = 3'b010;
        cyc();
        check("t6_req", 64'(mem_ctrl_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_req", 64'(mem_ctrl_req), 64'd0);
        check("t6_async_err", 64'(err), 64'd0);
        core_req = 3'b111;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t6_no_vld",  64'(core_vld), 64'd0);
        check("t6_req_rel", 64'(mem_ctrl_req), 64'd1);
        check("t6_rrptr0",  64'(mem_ctrl_addr[15:14]), 64'd0);
        mem_ctrl_vld = 1'b1;
        cyc();
        mem_ctrl_vld = 1'b0;
        core_req     = 3'b000;
        check("t6_vld", 64'(core_vld), 64'b001);
        cyc();

        // all_done is a one-cycle-delayed AND of core_done
        core_done = 3'b011;
        cyc();
        check("t7_partial", 64'(all_done), 64'd0);
        core_done = 3'b111;
        #1;
        check("t7_no_comb", 64'(all_done), 64'd0);
        cyc();
        check("t7_rise", 64'(all_done), 64'd1);
        core_done = 3'b011;
        cyc();
        check("t7_fall", 64'(all_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
